// File: rtl/uart_pkg.sv
// UART definitions shared by the transmit and receive paths: FSM state type,
// parity selection constants and the clock-to-baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4,
    TX_WAIT  = 3'd5
  } tx_state_t;

  // Driven from unreachable decode so that a corrupted state is visible in simulation.
  localparam tx_state_t TX_STATE_X = tx_state_t'(3'bxxx);

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses bit_done on the last count,
// then wraps; clr holds it at zero so every bit starts with a full period.
module uart_baud_timer #(
  parameter int BAUD_DIV = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_done
);

  localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign bit_done = (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter (start, 8 data LSB-first, parity, stop); line goes low
// one cycle after send is sampled in IDLE. send/din are ignored while busy.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter bit PARITY        = PARITY_ODD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx_out
);

  localparam int BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_par;
  logic       r_tx;
  logic       r_busy;

  logic       w_bit_done;
  logic       w_clr;

  // Timer idles at zero outside a frame; in-frame state changes land on bit
  // boundaries, where it wraps to zero by itself.
  assign w_clr = (r_state == TX_IDLE) || (r_state == TX_WAIT);

  uart_baud_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (send) begin
            r_shift   <= din;
            r_par     <= (^din) ^ PARITY;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= TX_START;
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        TX_START: begin
          if (w_bit_done) begin
            r_tx    <= r_shift[0];
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_bit_done) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_tx      <= r_par;
              r_state   <= TX_PAR;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[1];
            end
          end
        end
        TX_PAR: begin
          if (w_bit_done) begin
            r_tx    <= 1'b1;
            r_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_bit_done) begin
            r_busy  <= 1'b0;
            r_state <= send ? TX_WAIT : TX_IDLE;
          end
        end
        TX_WAIT: begin
          // A held request must drop before another frame can start.
          if (!send) begin
            r_state <= TX_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= TX_STATE_X;
        end
      endcase
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench: odd- and even-parity instances share stimulus; the line is
// sampled mid-bit on the falling edge and compared with hand-derived frames.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic       send;
  logic [7:0] din;
  logic       busy_o, tx_o;
  logic       busy_e, tx_e;

  int checks;
  int errors;

  uart_transmitter #(
    .CLK_FREQUENCY (1000),
    .BAUD_RATE     (100),
    .PARITY        (1'b1)
  ) u_dut_odd (
    .clk    (clk),
    .reset  (reset),
    .send   (send),
    .din    (din),
    .busy   (busy_o),
    .tx_out (tx_o)
  );

  uart_transmitter #(
    .CLK_FREQUENCY (1000),
    .BAUD_RATE     (100),
    .PARITY        (1'b0)
  ) u_dut_even (
    .clk    (clk),
    .reset  (reset),
    .send   (send),
    .din    (din),
    .busy   (busy_e),
    .tx_out (tx_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line value of bit slot b (0 start, 1..8 data, 9 parity, 10 stop).
  function automatic logic exp_bit(input logic [7:0] d, input logic odd, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Called on a falling edge: raise send with d, return one cycle later.
  task automatic pulse_send(input logic [7:0] d);
    send = 1'b1;
    din  = d;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Entered on the first start-bit cycle; checks 110 cycles plus the cycle after.
  // At cycle chg, din is changed and send is pulsed to show both are ignored.
  task automatic check_frame(input string name, input logic [7:0] d,
                             input int chg, input logic [7:0] chg_val);
    int n_bo, n_be;
    n_bo = 0;
    n_be = 0;
    for (int c = 0; c < 110; c++) begin
      if (c == 0) begin
        checks++;
        if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL %s start_latency: tx=%b busy=%b, required tx=0 busy=1", name, tx_o, busy_o);
        end
      end
      if (busy_o === 1'b1) n_bo++;
      if (busy_e === 1'b1) n_be++;
      if (c % 10 == 5) begin
        checks++;
        if (tx_o !== exp_bit(d, 1'b1, c / 10) || tx_e !== exp_bit(d, 1'b0, c / 10)) begin
          errors++;
          $display("FAIL %s bit%0d: odd=%b even=%b, required odd=%b even=%b", name, c / 10,
                   tx_o, tx_e, exp_bit(d, 1'b1, c / 10), exp_bit(d, 1'b0, c / 10));
        end
      end
      if (c == chg) begin
        din  = chg_val;
        send = 1'b1;
      end
      if (c == chg + 1) send = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n_bo != 110 || n_be != 110) begin
      errors++;
      $display("FAIL %s busy_len: odd=%0d even=%0d, required 110", name, n_bo, n_be);
    end
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_e !== 1'b1 || busy_e !== 1'b0) begin
      errors++;
      $display("FAIL %s after_stop: tx=%b/%b busy=%b/%b, required tx=1 busy=0",
               name, tx_o, tx_e, busy_o, busy_e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    send  = 1'b0;
    din   = 8'h00;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_e !== 1'b1 || busy_e !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: tx=%b/%b busy=%b/%b, required tx=1 busy=0", tx_o, tx_e, busy_o, busy_e);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_e !== 1'b1 || busy_e !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx=%b/%b busy=%b/%b, required tx=1 busy=0",
                 i, tx_o, tx_e, busy_o, busy_e);
      end
    end
  endtask

  task automatic test_single_frame;
    pulse_send(8'h41);
    check_frame("frame_41", 8'h41, 1000, 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_parity;
    logic [7:0] vec [3];
    vec[0] = 8'h07;
    vec[1] = 8'hFF;
    vec[2] = 8'h00;
    foreach (vec[k]) begin
      pulse_send(vec[k]);
      check_frame($sformatf("parity_%02h", vec[k]), vec[k], 1000, 8'h00);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_held_send;
    int bad;
    bad  = 0;
    send = 1'b1;
    din  = 8'h55;
    @(negedge clk);
    check_frame("held_first", 8'h55, 1000, 8'h00);
    for (int c = 110; c < 300; c++) begin
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_no_retx: %0d cycles active, required 0", bad);
    end
    send = 1'b0;
    repeat (2) @(negedge clk);
    pulse_send(8'h55);
    check_frame("held_second", 8'h55, 1000, 8'h00);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_input_stability;
    pulse_send(8'h55);
    check_frame("din_change", 8'h55, 30, 8'hAA);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    pulse_send(8'h33);
    repeat (45) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_e !== 1'b1 || busy_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: tx=%b/%b busy=%b/%b, required tx=1 busy=0", tx_o, tx_e, busy_o, busy_e);
    end
    reset = 1'b0;
    @(negedge clk);
    pulse_send(8'h96);
    check_frame("after_reset", 8'h96, 1000, 8'h00);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    pulse_send(8'h3C);
    check_frame("b2b_first", 8'h3C, 1000, 8'h00);
    // Single idle cycle between the stop bit and the next start bit.
    pulse_send(8'hC3);
    check_frame("b2b_second", 8'hC3, 1000, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_parity();
    test_held_send();
    test_input_stability();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
